// File: rtl/mx_pkg.sv
// Shared constants and buffer type for the multi-channel bit-serial MX cell.
package mx_pkg;

    localparam int unsigned CHANNELS_DEF = 4;
    localparam int unsigned LANES_DEF    = 2;
    localparam int unsigned WEIGHT_W_DEF = 8;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned ACC_W_DEF    = 32;

    function automatic int unsigned prod_w(input int unsigned data_w, input int unsigned weight_w);
        return data_w + weight_w;
    endfunction

    localparam int unsigned PROD_W = prod_w(DATA_W_DEF, WEIGHT_W_DEF);

    // One product slot: unsigned magnitude, weight sign (1 = non-negative), occupancy.
    typedef struct packed {
        logic [PROD_W-1:0] prod;
        logic              sign;
        logic              valid;
    } mx_buf_t;

endpackage

// File: rtl/mx_serial_acc_chan.sv
// One accumulation channel: pending/active product slots and a bit-serial
// adder streaming acc_in +/- product, LSB first, with a sticky error flag.
module mx_serial_acc_chan
    import mx_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [PROD_W-1:0] wr_prod_i,
    input  logic              wr_sign_i,
    input  logic              acc_i,
    input  logic              mac_en_i,
    input  logic              clr_i,
    output logic              result_o,
    output logic              err_o
);

    localparam int unsigned   KW    = $clog2(ACC_W);
    localparam logic [KW-1:0] K_MAX = KW'(ACC_W - 1);
    localparam mx_buf_t BUF_EMPTY   = '{prod: '0, sign: 1'b1, valid: 1'b0};
    localparam mx_buf_t BUF_ZERO    = '{prod: '0, sign: 1'b1, valid: 1'b1};

    mx_buf_t           pend_q, pend_d;
    mx_buf_t           act_q, act_d;
    mx_buf_t           cur;
    logic [KW-1:0]     k_q, k_d, k_cur;
    logic              carry_q, carry_d, carry_cur;
    logic              result_q, result_d;
    logic              err_q, err_d;
    logic [PROD_W-1:0] prod_shift;
    logic              add_bit;

    always_comb begin
        pend_d     = pend_q;
        act_d      = act_q;
        k_d        = k_q;
        carry_d    = carry_q;
        result_d   = 1'b0;
        err_d      = err_q;
        cur        = act_q;
        k_cur      = k_q;
        carry_cur  = carry_q;
        prod_shift = '0;
        add_bit    = 1'b0;

        // Word start: pull the pending product in; a negative sign seeds carry for the +1.
        if (mac_en_i && clr_i) begin
            if (pend_q.valid) begin
                cur = pend_q;
            end else begin
                cur   = BUF_ZERO;
                err_d = 1'b1;
            end
            k_cur        = '0;
            carry_cur    = ~cur.sign;
            pend_d.valid = 1'b0;
        end

        // Bits past the product width shift in as 0, which sign-extends after inversion.
        if (mac_en_i) begin
            prod_shift = cur.prod >> k_cur;
            add_bit    = (cur.valid & prod_shift[0]) ^ ~cur.sign;
            result_d   = acc_i ^ add_bit ^ carry_cur;
            carry_d    = (acc_i & add_bit) | (acc_i & carry_cur) | (add_bit & carry_cur);
            act_d      = cur;
            k_d        = (k_cur == K_MAX) ? k_cur : k_cur + KW'(1);
        end

        // A write landing on a still-full slot is an overrun; a same-cycle clr has freed it.
        if (wr_en_i) begin
            if (pend_d.valid) begin
                err_d = 1'b1;
            end
            pend_d = '{prod: wr_prod_i, sign: wr_sign_i, valid: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q   <= BUF_EMPTY;
            act_q    <= BUF_EMPTY;
            k_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            act_q    <= act_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign result_o = result_q;
    assign err_o    = err_q;

endmodule

// File: rtl/j_mx_cell_multi.sv
// Bit-serial MX cell: serial weight load, shift-add multiply of unsigned data,
// round-robin hand-off to CHANNELS serial accumulators, and systolic chaining.
module j_mx_cell_multi
    import mx_pkg::*;
#(
    parameter int unsigned CHANNELS = CHANNELS_DEF,
    parameter int unsigned LANES    = LANES_DEF,
    parameter int unsigned WEIGHT_W = WEIGHT_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES-1:0]    dataflow_in,
    input  logic                dataflow_valid_i,
    input  logic                update_w_i,
    input  logic                weight_sign_i,
    input  logic [CHANNELS-1:0] accumulation_in,
    input  logic [CHANNELS-1:0] mac_en_i,
    input  logic [CHANNELS-1:0] clr_and_plus_one_i,
    output logic [CHANNELS-1:0] result,
    output logic [CHANNELS-1:0] mac_en_o,
    output logic [CHANNELS-1:0] clr_and_plus_one_o,
    output logic [LANES-1:0]    dataflow_out,
    output logic                dataflow_valid_o,
    output logic                update_w_o,
    output logic                weight_sign_o,
    output logic [CHANNELS-1:0] err_o
);

    localparam int unsigned     PW        = prod_w(DATA_W, WEIGHT_W);
    localparam int unsigned     DCW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned     PTRW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DCW-1:0]  DCNT_LAST = DCW'(DATA_W - 1);
    localparam logic [PTRW-1:0] PTR_LAST  = PTRW'(CHANNELS - 1);

    logic [WEIGHT_W-1:0] w_q, w_d;
    logic                wsign_q, wsign_d;
    logic [PW-1:0]       build_q, build_d, build_sum;
    logic [DCW-1:0]      dcnt_q, dcnt_d;
    logic [PTRW-1:0]     ptr_q, ptr_d;
    logic                wr_fire;
    logic [CHANNELS-1:0] wr_en;
    logic [PROD_W-1:0]   wr_prod;

    logic [LANES-1:0]    df_q, df_d;
    logic                dfv_q, dfv_d;
    logic                upd_q, upd_d;
    logic                sgn_q, sgn_d;
    logic [CHANNELS-1:0] mac_q, mac_d;
    logic [CHANNELS-1:0] clr_q, clr_d;

    always_comb begin
        w_d       = w_q;
        wsign_d   = wsign_q;
        build_d   = build_q;
        dcnt_d    = dcnt_q;
        ptr_d     = ptr_q;
        wr_fire   = 1'b0;
        build_sum = '0;

        df_d  = dataflow_in;
        dfv_d = dataflow_valid_i;
        upd_d = update_w_i;
        sgn_d = weight_sign_i;
        mac_d = mac_en_i;
        clr_d = clr_and_plus_one_i;

        // Weight load has priority and abandons any half-built data word.
        if (update_w_i) begin
            w_d     = WEIGHT_W'({dataflow_in, w_q} >> LANES);
            wsign_d = weight_sign_i;
            build_d = '0;
            dcnt_d  = '0;
        end else if (dataflow_valid_i) begin
            build_sum = build_q + (dataflow_in[0] ? (PW'(w_q) << dcnt_q) : PW'(0));
            if (dcnt_q == DCNT_LAST) begin
                wr_fire = 1'b1;
                build_d = '0;
                dcnt_d  = '0;
                ptr_d   = (ptr_q == PTR_LAST) ? PTRW'(0) : ptr_q + PTRW'(1);
            end else begin
                build_d = build_sum;
                dcnt_d  = dcnt_q + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q     <= '0;
            wsign_q <= 1'b1;
            build_q <= '0;
            dcnt_q  <= '0;
            ptr_q   <= '0;
            df_q    <= '0;
            dfv_q   <= 1'b0;
            upd_q   <= 1'b0;
            sgn_q   <= 1'b0;
            mac_q   <= '0;
            clr_q   <= '0;
        end else begin
            w_q     <= w_d;
            wsign_q <= wsign_d;
            build_q <= build_d;
            dcnt_q  <= dcnt_d;
            ptr_q   <= ptr_d;
            df_q    <= df_d;
            dfv_q   <= dfv_d;
            upd_q   <= upd_d;
            sgn_q   <= sgn_d;
            mac_q   <= mac_d;
            clr_q   <= clr_d;
        end
    end

    assign wr_prod = PROD_W'(build_sum);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign wr_en[c] = wr_fire && (ptr_q == PTRW'(c));

        mx_serial_acc_chan #(
            .ACC_W (ACC_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (wr_en[c]),
            .wr_prod_i (wr_prod),
            .wr_sign_i (wsign_q),
            .acc_i     (accumulation_in[c]),
            .mac_en_i  (mac_en_i[c]),
            .clr_i     (clr_and_plus_one_i[c]),
            .result_o  (result[c]),
            .err_o     (err_o[c])
        );
    end

    assign mac_en_o           = mac_q;
    assign clr_and_plus_one_o = clr_q;
    assign dataflow_out       = df_q;
    assign dataflow_valid_o   = dfv_q;
    assign update_w_o         = upd_q;
    assign weight_sign_o      = sgn_q;

endmodule

// File: tb/tb_j_mx_cell_multi.sv
// Self-checking bench for j_mx_cell_multi: directed scenarios plus a randomized
// sweep scored against a signed-arithmetic model of weight, round-robin and slots.
module tb_j_mx_cell_multi;

    localparam int CH = 4;
    localparam int LN = 2;
    localparam int WW = 8;
    localparam int DW = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [LN-1:0] dataflow_in;
    logic          dataflow_valid_i, update_w_i, weight_sign_i;
    logic [CH-1:0] accumulation_in, mac_en_i, clr_and_plus_one_i;
    logic [CH-1:0] result, mac_en_o, clr_and_plus_one_o, err_o;
    logic [LN-1:0] dataflow_out;
    logic          dataflow_valid_o, update_w_o, weight_sign_o;

    int total = 0;
    int bad   = 0;
    int align_err;
    int chain_err;

    // Model state: signed weight, next channel, pending slots, sticky errors.
    int            m_w;
    int            m_ptr;
    logic [CH-1:0] m_pv;
    longint        m_pp [CH];
    logic [CH-1:0] m_err;

    logic [AW-1:0] acc_v [CH];
    logic [AW-1:0] got_v [CH];
    logic [AW-1:0] exp_v [CH];

    always #5 clk = ~clk;

    j_mx_cell_multi dut (
        .clk                (clk),
        .reset              (reset),
        .dataflow_in        (dataflow_in),
        .dataflow_valid_i   (dataflow_valid_i),
        .update_w_i         (update_w_i),
        .weight_sign_i      (weight_sign_i),
        .accumulation_in    (accumulation_in),
        .mac_en_i           (mac_en_i),
        .clr_and_plus_one_i (clr_and_plus_one_i),
        .result             (result),
        .mac_en_o           (mac_en_o),
        .clr_and_plus_one_o (clr_and_plus_one_o),
        .dataflow_out       (dataflow_out),
        .dataflow_valid_o   (dataflow_valid_o),
        .update_w_o         (update_w_o),
        .weight_sign_o      (weight_sign_o),
        .err_o              (err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dataflow_in        = '0;
        dataflow_valid_i   = 1'b0;
        update_w_i         = 1'b0;
        weight_sign_i      = 1'b0;
        accumulation_in    = '0;
        mac_en_i           = '0;
        clr_and_plus_one_i = '0;
    endtask

    task automatic model_reset();
        m_w   = 0;
        m_ptr = 0;
        m_pv  = '0;
        m_err = '0;
        for (int c = 0; c < CH; c++) m_pp[c] = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic load_w(input int w, input bit with_valid);
        int unsigned   mag;
        logic [LN-1:0] beat;
        mag = (w < 0) ? -w : w;
        for (int j = 0; j < WW / LN; j++) begin
            beat             = LN'(mag >> (LN * j));
            update_w_i       = 1'b1;
            weight_sign_i    = (w >= 0);
            dataflow_valid_i = with_valid;
            dataflow_in      = beat;
            tick();
            if (dataflow_out !== beat || update_w_o !== 1'b1 ||
                weight_sign_o !== (w >= 0) || dataflow_valid_o !== with_valid)
                chain_err++;
        end
        update_w_i       = 1'b0;
        dataflow_valid_i = 1'b0;
        dataflow_in      = '0;
        m_w              = w;
    endtask

    task automatic send_word(input int d, input bit gaps);
        int i;
        i = 0;
        while (i < DW) begin
            dataflow_in = LN'($urandom);
            if (gaps && $urandom_range(0, 2) == 0) begin
                dataflow_valid_i = 1'b0;
            end else begin
                dataflow_valid_i = 1'b1;
                dataflow_in[0]   = 1'((d >> i) & 1);
                i++;
            end
            tick();
        end
        dataflow_valid_i = 1'b0;
        dataflow_in      = '0;
        if (m_pv[m_ptr]) m_err[m_ptr] = 1'b1;
        m_pp[m_ptr] = longint'(d) * longint'(m_w);
        m_pv[m_ptr] = 1'b1;
        m_ptr       = (m_ptr + 1) % CH;
    endtask

    // Streams one ACC_W-bit word on every channel in mask, assembling got_v.
    task automatic stream(input logic [CH-1:0] mask, input bit gaps);
        int            idx [CH];
        logic [CH-1:0] en, cl;
        int            cyc;
        bit            busy;
        for (int c = 0; c < CH; c++) begin
            idx[c]   = mask[c] ? 0 : AW;
            got_v[c] = '0;
            if (mask[c]) begin
                longint prod;
                if (m_pv[c]) begin
                    prod = m_pp[c];
                end else begin
                    prod     = 0;
                    m_err[c] = 1'b1;
                end
                m_pv[c]  = 1'b0;
                exp_v[c] = acc_v[c] + 32'(prod);
            end
        end
        cyc  = 0;
        busy = (mask != '0);
        while (busy && cyc < 4000) begin
            for (int c = 0; c < CH; c++) begin
                en[c] = (idx[c] < AW) && (!gaps || $urandom_range(0, 3) != 0);
                cl[c] = en[c] && (idx[c] == 0);
                mac_en_i[c]           = en[c];
                clr_and_plus_one_i[c] = cl[c];
                accumulation_in[c]    = en[c] ? acc_v[c][idx[c]] : 1'($urandom);
            end
            tick();
            busy = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (mac_en_o[c] !== en[c] || clr_and_plus_one_o[c] !== cl[c]) align_err++;
                if (en[c]) begin
                    got_v[c][idx[c]] = result[c];
                    idx[c]++;
                end else if (result[c] !== 1'b0) begin
                    align_err++;
                end
                if (idx[c] < AW) busy = 1'b1;
            end
            cyc++;
        end
        mac_en_i           = '0;
        clr_and_plus_one_i = '0;
        accumulation_in    = '0;
        total++;
        if (busy) begin
            bad++;
            $display("FAIL stream_timeout cycles=%0d required_done=1", cyc);
        end
    endtask

    task automatic test_reset();
        dataflow_in        = '1;
        dataflow_valid_i   = 1'b1;
        update_w_i         = 1'b1;
        weight_sign_i      = 1'b1;
        accumulation_in    = '1;
        mac_en_i           = '1;
        clr_and_plus_one_i = '1;
        reset              = 1'b1;
        tick();
        total++;
        if ({result, mac_en_o, clr_and_plus_one_o, dataflow_out, dataflow_valid_o,
             update_w_o, weight_sign_o, err_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {result, mac_en_o, clr_and_plus_one_o,
                     dataflow_out, dataflow_valid_o, update_w_o, weight_sign_o, err_o});
        end
        do_reset();
    endtask

    task automatic test_weight_load();
        do_reset();
        chain_err = 0;
        align_err = 0;
        load_w(5, 1'b0);
        total++;
        if (chain_err !== 0) begin bad++; $display("FAIL wl_chain errors=%0d want=0", chain_err); end
        send_word(3, 1'b0);
        acc_v[0] = 32'd7;
        stream(4'b0001, 1'b0);
        total++;
        if (got_v[0] !== 32'd22) begin bad++; $display("FAIL wl_result got=%0d want=22", got_v[0]); end
        total++;
        if (align_err !== 0) begin bad++; $display("FAIL wl_mac_en_align errors=%0d want=0", align_err); end
        total++;
        if (err_o !== m_err) begin bad++; $display("FAIL wl_err got=%b want=%b", err_o, m_err); end
    endtask

    task automatic test_negative();
        do_reset();
        load_w(-3, 1'b0);
        send_word(5, 1'b0);
        load_w(-10, 1'b0);
        send_word(9, 1'b1);
        acc_v[0] = 32'd7;
        acc_v[1] = 32'(-10);
        stream(4'b0011, 1'b1);
        total++;
        if (got_v[0] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL neg_ch0 got=%h want=fffffff8", got_v[0]); end
        total++;
        if (got_v[1] !== 32'hFFFF_FF9C) begin bad++; $display("FAIL neg_ch1 got=%h want=ffffff9c", got_v[1]); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] want [CH];
        do_reset();
        load_w(4, 1'b0);
        for (int d = 0; d < CH; d++) send_word(d, 1'b1);
        for (int c = 0; c < CH; c++) begin
            acc_v[c] = 32'(c);
            want[c]  = 32'(5 * c);
        end
        stream(4'b1111, 1'b1);
        for (int c = 0; c < CH; c++) begin
            total++;
            if (got_v[c] !== want[c]) begin
                bad++;
                $display("FAIL rr_ch%0d got=%0d want=%0d", c, got_v[c], want[c]);
            end
        end
        send_word(4, 1'b0);
        acc_v[0] = 32'd0;
        stream(4'b0001, 1'b0);
        total++;
        if (got_v[0] !== 32'd16) begin bad++; $display("FAIL rr_wrap got=%0d want=16", got_v[0]); end
        total++;
        if (err_o !== 4'b0000) begin bad++; $display("FAIL rr_err got=%b want=0000", err_o); end
    endtask

    task automatic test_boundaries();
        do_reset();
        load_w(255, 1'b0);
        send_word(255, 1'b0);
        acc_v[0] = 32'hFFFF_0000;
        stream(4'b0001, 1'b0);
        total++;
        if (got_v[0] !== 32'hFFFF_FE01) begin bad++; $display("FAIL bnd_max got=%h want=fffffe01", got_v[0]); end
        send_word(10, 1'b0);
        send_word(1, 1'b0);
        send_word(1, 1'b0);
        send_word(2, 1'b0);
        send_word(20, 1'b0);
        total++;
        if (err_o !== 4'b0010) begin bad++; $display("FAIL bnd_overrun_flag got=%b want=0010", err_o); end
        acc_v[1] = 32'd5;
        stream(4'b0010, 1'b0);
        total++;
        if (got_v[1] !== 32'd5105) begin bad++; $display("FAIL bnd_overrun_value got=%0d want=5105", got_v[1]); end
        acc_v[2] = 32'd9;
        stream(4'b0100, 1'b0);
        total++;
        if (got_v[2] !== 32'd264) begin bad++; $display("FAIL bnd_ch2 got=%0d want=264", got_v[2]); end
        acc_v[2] = 32'd77;
        stream(4'b0100, 1'b1);
        total++;
        if (got_v[2] !== 32'd77) begin bad++; $display("FAIL bnd_underrun_value got=%0d want=77", got_v[2]); end
        total++;
        if (err_o !== 4'b0110) begin bad++; $display("FAIL bnd_underrun_flag got=%b want=0110", err_o); end
    endtask

    task automatic test_mid_op();
        do_reset();
        load_w(3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dataflow_valid_i = 1'b1;
            dataflow_in      = 2'b11;
            tick();
        end
        load_w(6, 1'b1);
        send_word(7, 1'b0);
        acc_v[0] = 32'd100;
        stream(4'b0001, 1'b0);
        total++;
        if (got_v[0] !== 32'd142) begin bad++; $display("FAIL mid_abort got=%0d want=142", got_v[0]); end
        total++;
        if (err_o !== 4'b0000) begin bad++; $display("FAIL mid_abort_err got=%b want=0000", err_o); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        load_w(5, 1'b0);
        send_word(6, 1'b0);
        acc_v[2] = 32'd1;
        stream(4'b0100, 1'b0);
        total++;
        if (err_o !== 4'b0100) begin bad++; $display("FAIL rst_pre_err got=%b want=0100", err_o); end
        mac_en_i[3]           = 1'b1;
        clr_and_plus_one_i[3] = 1'b1;
        accumulation_in[3]    = 1'b1;
        dataflow_valid_i      = 1'b1;
        dataflow_in           = 2'b01;
        tick();
        clr_and_plus_one_i[3] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        total++;
        if ({result, mac_en_o, clr_and_plus_one_o, dataflow_out, dataflow_valid_o,
             update_w_o, weight_sign_o, err_o} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%h want=0", {result, mac_en_o, clr_and_plus_one_o,
                     dataflow_out, dataflow_valid_o, update_w_o, weight_sign_o, err_o});
        end
        reset = 1'b0;
        idle_inputs();
        model_reset();
        acc_v[0] = 32'd3;
        stream(4'b0001, 1'b0);
        total++;
        if (got_v[0] !== 32'd3) begin bad++; $display("FAIL rst_pending_cleared got=%0d want=3", got_v[0]); end
        total++;
        if (err_o !== 4'b0001) begin bad++; $display("FAIL rst_underrun_flag got=%b want=0001", err_o); end
        load_w(2, 1'b0);
        send_word(4, 1'b0);
        stream(4'b0001, 1'b0);
        total++;
        if (got_v[0] !== 32'd11) begin bad++; $display("FAIL rst_ptr got=%0d want=11", got_v[0]); end
    endtask

    task automatic test_sweep();
        logic [CH-1:0] mask;
        do_reset();
        align_err = 0;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < CH; k++) begin
                load_w(int'($urandom_range(0, 19)) - 10, 1'($urandom));
                send_word(int'($urandom_range(0, 12)), 1'b1);
            end
            mask = (r == 0) ? 4'b1111 : CH'($urandom_range(1, 15));
            for (int c = 0; c < CH; c++) acc_v[c] = 32'(int'($urandom_range(0, 22)) - 10);
            stream(mask, 1'b1);
            for (int c = 0; c < CH; c++) begin
                if (mask[c]) begin
                    total++;
                    if (got_v[c] !== exp_v[c]) begin
                        bad++;
                        $display("FAIL sweep_r%0d_ch%0d got=%h want=%h", r, c, got_v[c], exp_v[c]);
                    end
                end
            end
            total++;
            if (err_o !== m_err) begin bad++; $display("FAIL sweep_err_r%0d got=%b want=%b", r, err_o, m_err); end
        end
        total++;
        if (align_err !== 0) begin bad++; $display("FAIL sweep_align errors=%0d want=0", align_err); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        align_err = 0;
        chain_err = 0;
        tick();
        test_reset();
        test_weight_load();
        test_negative();
        test_round_robin();
        test_boundaries();
        test_mid_op();
        test_reset_mid_stream();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/j_mx_cell_multi.md
Name: j_mx_cell_multi

Overview:
Parametrised successor to the bit-serial MX cell. It holds one signed weight, loaded over LANES serial lanes. Unsigned bit-serial data words are multiplied by the weight using shift-add only; each product is handed round-robin to one of CHANNELS accumulation channels. Each channel streams acc_in ± product bit-serially, LSB first, and forwards its control to the next cell in a systolic row.

Parameters:
CHANNELS, 4, number of independent accumulation channels
LANES, 2, weight-load lanes; WEIGHT_W % LANES must be 0
WEIGHT_W, 8, weight magnitude width
DATA_W, 8, unsigned data word width
ACC_W, 32, accumulation/result word width; must be >= DATA_W+WEIGHT_W+1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dataflow_in  in  LANES  serial weight lanes; lane 0 also carries data bits
dataflow_valid_i  in  1  lane-0 data bit valid (ignored when update_w_i=1)
update_w_i  in  1  weight-load cycle
weight_sign_i  in  1  1 = weight >= 0, 0 = negative
accumulation_in  in  CHANNELS  per-channel serial addend, LSB first
mac_en_i  in  CHANNELS  per-channel serial bit valid
clr_and_plus_one_i  in  CHANNELS  marks bit 0 of a channel word
result  out  CHANNELS  per-channel serial sum, LSB first
mac_en_o  out  CHANNELS  mac_en_i delayed 1 cycle, aligned with result
clr_and_plus_one_o  out  CHANNELS  clr_and_plus_one_i delayed 1 cycle
dataflow_out / dataflow_valid_o / update_w_o / weight_sign_o  out  LANES/1/1/1  inputs delayed 1 cycle, for chaining
err_o  out  CHANNELS  sticky overrun/underrun flag

Behaviour:
- Reset: all outputs 0; weight = 0, sign positive; round-robin pointer 0; bit counters 0; all pending/active buffers empty; carries 0. Reset mid-stream aborts every operation with no partial output.
- Weight load: each update_w_i cycle, w <= {dataflow_in, w[WEIGHT_W-1:LANES]}. Lane l carries bit LANES*j+l on beat j, so a full load takes WEIGHT_W/LANES beats. weight_sign_i is captured on every update cycle; the last beat wins.
- Weight load aborts any in-progress data word: build register and data bit counter are cleared.
- Data multiply: each valid cycle carries bit i (counter 0..DATA_W-1). build <= build + (bit ? |w|<<i : 0).
  - On bit DATA_W-1, the final sum and the current sign are written to pending[ptr]; ptr increments and wraps to 0 at CHANNELS-1; build and counter clear.
  - Products already written keep the old weight if the weight changes later.
- Channel c, on a cycle with mac_en_i[c]=1:
  - If clr_and_plus_one_i[c]=1: active <= pending[c], pending empties, k = 0, carry_in = negative sign (this is the +1 of two's-complement negation).
  - Addend bit = active[k] for k < DATA_W+WEIGHT_W, else 0; inverted when sign is negative.
  - result[c] <= acc_bit ^ addend_bit ^ carry (registered; 1-cycle latency). carry and k update; k saturates at ACC_W-1, giving sign extension.
- mac_en_i[c]=0: channel state holds; result[c] = 0 next cycle.
- The result word is (acc_in + s*data*|w|) mod 2^ACC_W.
- Underrun: clr with pending empty → product 0, sign positive, err_o[c] set.
- Overrun: a write to pending[c] while it is still full → overwrite and set err_o[c].
- Same-cycle clr and pending write on one channel: clr consumes the old pending and the new word becomes pending; no error.
- update_w_i and dataflow_valid_i both high: weight load wins and the data bit is dropped.

Decomposition:
- Package mx_pkg: default parameter constants, PROD_W = DATA_W+WEIGHT_W localparam function, and a typedef struct {prod, sign, valid} for pending/active buffers.
- One sub-module, mx_serial_acc_chan: pending/active buffers, bit counter, carry flop and result flop, instantiated CHANNELS times via generate.
- The top level holds the weight shift register, the shift-add builder, the round-robin pointer and the chaining delays.

Test Plan:
- Weight load: w = +5 (2 lanes, 4 beats); data 3 to ch0; acc 7 → ch0 result word 22, mac_en_o aligned 1 cycle after mac_en_i.
- Negative weight: w = -3, data 5, acc 7 → 0xFFFFFFF8 (-8); w = -10, data 9, acc -10 → -100.
- Round-robin: w = 4, data 0,1,2,3,4 → pending on ch0..3 then ch0 again; acc = idx → ch0=0, ch1=5, ch2=10, ch3=15; later ch0 = 16.
- Boundaries: w = 255 (max), data 255 → 65025 + acc; second word to a full ch1 pending → err_o[1]=1 and newer product used; clr with empty pending → result = acc and err set.
- Mid-operation: update_w_i pulse at data bit 4 → no pending written; reset during streaming → all outputs 0 next cycle and err_o cleared.
- Sweep: w in -10..9, data 0..12, acc -10..12 across 4 channels with random mac_en gaps; scoreboard every result word against (data*w + acc) mod 2^32.
